// File: rtl/exp_sum_buffer.sv
// Exponent vector buffer feeding log_divider: stores each numerator while summing them,
// then replays every stored numerator alongside the frozen 64-bit sum.
module exp_sum_buffer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum_hi,
  output logic [31:0]   out_sum_lo,
  output logic [DW-1:0] out_num,
  output logic          out_last,
  output logic [AW:0]   out_count,
  output logic          err_overflow
);

  typedef enum logic {ACCUM, REPLAY} state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] mem [DEPTH];
  logic [63:0]   sum;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          accept;
  logic          xfer;
  logic          close;
  logic          force_close;
  logic [AW:0]   count_inc;
  logic [63:0]   sum_inc;
  logic [AW:0]   rd_next;

  // Handshake qualifiers and next-value arithmetic
  always_comb begin
    accept      = in_valid && in_ready;
    xfer        = out_valid && out_ready;
    count_inc   = count + (AW+1)'(1);
    sum_inc     = sum + 64'(in_data);
    rd_next     = {1'b0, rd_ptr} + (AW+1)'(1);
    force_close = accept && !in_last && (count_inc == (AW+1)'(DEPTH));
    close       = accept && (in_last || (count_inc == (AW+1)'(DEPTH)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (close)             state_next = REPLAY;
      REPLAY:  if (xfer && out_last)  state_next = ACCUM;
      default:                        state_next = ACCUM;
    endcase
  end

  // Buffer storage has no reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_sum_hi   <= '0;
      out_sum_lo   <= '0;
      out_num      <= '0;
      out_count    <= '0;
    end else begin
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == REPLAY);
      if (state == ACCUM) begin
        if (accept) begin
          sum    <= sum_inc;
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count_inc;
        end
        if (force_close) err_overflow <= 1'b1;
        if (close) begin
          // Entry 0 may be the beat being written this same edge
          rd_ptr     <= '0;
          out_num    <= (wr_ptr == '0) ? in_data : mem[0];
          out_sum_hi <= sum_inc[63:32];
          out_sum_lo <= sum_inc[31:0];
          out_count  <= count_inc;
          out_last   <= (count_inc == (AW+1)'(1));
        end
      end else if (xfer) begin
        if (out_last) begin
          sum      <= '0;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          count    <= '0;
          out_last <= 1'b0;
        end else begin
          rd_ptr   <= rd_next[AW-1:0];
          out_num  <= mem[rd_next[AW-1:0]];
          out_last <= (rd_next == (count - (AW+1)'(1)));
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Randomized self-checking bench for exp_sum_buffer against a queue-based vector model.
module tb_exp_sum_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_sum_hi;
  logic [31:0]   out_sum_lo;
  logic [DW-1:0] out_num;
  logic          out_last;
  logic [AW:0]   out_count;
  logic          err_overflow;

  int checks   = 0;
  int failures = 0;

  logic [31:0]     vec [$];
  longint unsigned exp_sum;
  int              exp_len;
  bit              exp_err;

  exp_sum_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_hi(out_sum_hi), .out_sum_lo(out_sum_lo), .out_num(out_num),
    .out_last(out_last), .out_count(out_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives vec[0..n-1]; the model sum is taken over the values sent
  task automatic send_vec(input int n, input bit with_last, input bit gaps);
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      check("acc_ready", in_ready, 1);
      check("acc_no_valid", out_valid, 0);
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = with_last && (i == n - 1);
      exp_sum += longint'(vec[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_len  = n;
    if (!with_last && n == DEPTH) exp_err = 1'b1;
    check("first_valid_latency", out_valid, 1);
  endtask

  // Collects up to max_xfer replayed elements; out_ready from pattern bits or random
  task automatic recv_vec(input int max_xfer, input bit use_pat, input logic [31:0] pat);
    int idx = 0;
    int k = 0;
    bit r;
    while (idx < exp_len && idx < max_xfer && k < 500) begin
      r = use_pat ? pat[k % 32] : ($urandom_range(0, 3) != 0);
      k++;
      check("rp_valid", out_valid, 1);
      check("rp_in_ready", in_ready, 0);
      check("rp_num", out_num, vec[idx]);
      check("rp_sum_hi", out_sum_hi, exp_sum[63:32]);
      check("rp_sum_lo", out_sum_lo, exp_sum[31:0]);
      check("rp_last", out_last, (idx == exp_len - 1));
      check("rp_count", out_count, exp_len);
      check("rp_err", err_overflow, exp_err);
      out_ready = r;
      in_valid  = !(r && idx == exp_len - 1) && ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      in_last   = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      if (r) idx++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    if (k >= 500) check("replay_timeout", 0, 1);
    if (idx == exp_len) begin
      check("end_in_ready", in_ready, 1);
      check("end_out_valid", out_valid, 0);
      check("end_out_last", out_last, 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sum_hi", out_sum_hi, 0);
    check("rst_sum_lo", out_sum_lo, 0);
    check("rst_num", out_num, 0);
    check("rst_count", out_count, 0);
    check("rst_err", err_overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    vec = '{32'd10, 32'd20, 32'd30, 32'd40};
    send_vec(4, 1, 0);
    check("t1_sum_lo", out_sum_lo, 100);
    recv_vec(99, 1, 32'hFFFF_FFFF);

    vec = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    send_vec(3, 1, 0);
    check("t2_sum_hi", out_sum_hi, 32'h2);
    check("t2_sum_lo", out_sum_lo, 32'hFFFF_FFFD);
    recv_vec(99, 1, 32'hFFFF_FFFF);

    vec = '{32'd5, 32'd7};
    send_vec(2, 1, 0);
    recv_vec(99, 1, 32'b10100);

    vec = '{32'd42};
    send_vec(1, 1, 0);
    check("t4_single_last", out_last, 1);
    recv_vec(99, 1, 32'hFFFF_FFFF);
    vec = '{32'd3, 32'd4};
    send_vec(2, 1, 0);
    check("t4_b2b_sum_lo", out_sum_lo, 7);
    recv_vec(99, 1, 32'hFFFF_FFFF);

    for (int v = 0; v < 25; v++) begin
      int n;
      n = $urandom_range(1, DEPTH - 1);
      vec.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       vec.push_back(32'h0);
          1:       vec.push_back(32'hFFFF_FFFF);
          default: vec.push_back($urandom);
        endcase
      end
      send_vec(n, 1, 1);
      recv_vec(99, 0, 32'h0);
    end

    vec.delete();
    for (int i = 0; i < DEPTH; i++) vec.push_back(32'd1);
    send_vec(DEPTH, 0, 0);
    check("ovf_err", err_overflow, 1);
    check("ovf_sum_lo", out_sum_lo, DEPTH);
    recv_vec(99, 0, 32'h0);
    vec = '{32'd11, 32'd12, 32'd13};
    send_vec(3, 1, 1);
    recv_vec(99, 0, 32'h0);

    vec = '{$urandom, $urandom, $urandom, $urandom};
    send_vec(4, 1, 0);
    recv_vec(2, 1, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    exp_err = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum_lo", out_sum_lo, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_err", err_overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vec = '{32'd9};
    send_vec(1, 1, 0);
    check("post_rst_sum_lo", out_sum_lo, 9);
    check("post_rst_count", out_count, 1);
    recv_vec(99, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "global timeout");
  end
endmodule
